// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state encoding, opcode and ALUOp constants for the multicycle MIPS control FSM
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_LOAD_WB   = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_LUI       = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_BREAK = 6'h0D;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle MIPS datapath
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Halted,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [3:0] LAST_BEAT = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       is_lw_q, is_lw_d;
  logic       mem_done;

  assign mem_done = (wait_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    case (state_q)
      S_RST:       state_d = S_FETCH;
      S_FETCH:     if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        // lw/sw choice is latched here so MEM_ADDR does not look at the IR
        is_lw_d = (Opcode == OP_LW);
        case (Opcode)
          OP_RTYPE:      state_d = (Funct == FUNCT_BREAK) ? S_HALT : S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_LUI:        state_d = S_LUI;
          default:       state_d = S_FETCH;
        endcase
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_done) state_d = S_LOAD_WB;
      S_LOAD_WB:   state_d = S_FETCH;
      S_MEM_WRITE: if (mem_done) state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_LUI:       state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_RST;
    endcase
  end

  // Counter restarts whenever the state changes, so each memory state begins at beat 0
  always_comb begin
    wait_d = 4'd0;
    if (state_d == state_q &&
        (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      wait_q  <= 4'd0;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      is_lw_q <= is_lw_d;
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 2'b00;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = ALUOP_ADD;
    PCSource  = 2'b00;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_done;
        PCWrite = mem_done;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        IllegalOp = !(Opcode == OP_RTYPE || Opcode == OP_LW || Opcode == OP_SW ||
                      Opcode == OP_BEQ || Opcode == OP_BNE || Opcode == OP_J ||
                      Opcode == OP_LUI);
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_LOAD_WB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_SUB;
        PCSource = 2'b01;
        PCWrite  = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_LUI: begin
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench running one program on MEM_LAT=1,2,3 instances
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pcw, iord, mr, mw, irw, rdst;
    logic [1:0] m2r;
    logic       rw, asa;
    logic [1:0] asb, aop, pcs;
    logic       hlt, ill;
    logic [3:0] st;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic [5:0] op  [3];
  logic [5:0] fn  [3];
  logic       zr  [3];
  ctl_t       act [3];
  ctl_t       q   [3][$];

  int checks = 0;
  int errors = 0;
  bit all_done = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcw, iord, mr, mw, irw, rdst, rw, asa, hlt, ill;
    logic [1:0] m2r, asb, aop, pcs;
    logic [3:0] st;
    multicycle_control #(.MEM_LAT(g + 1)) u_dut (
      .clk(clk), .reset(rst[g]), .Opcode(op[g]), .Funct(fn[g]), .Zero(zr[g]),
      .PCWrite(pcw), .IorD(iord), .MemRead(mr), .MemWrite(mw), .IRWrite(irw),
      .RegDst(rdst), .MemtoReg(m2r), .RegWrite(rw), .ALUSrcA(asa), .ALUSrcB(asb),
      .ALUOp(aop), .PCSource(pcs), .Halted(hlt), .IllegalOp(ill), .State(st)
    );
    assign act[g] = {pcw, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, pcs, hlt, ill, st};
  end

  function automatic ctl_t ex(input logic [3:0] s);
    ctl_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic step(input int g, input ctl_t e);
    q[g].push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pushes the expected per-cycle trace of one instruction starting in FETCH
  task automatic instr(input int g, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input bit abort_mw);
    int L = g + 1;
    ctl_t e;
    op[g] = o; fn[g] = f; zr[g] = z;
    for (int i = 0; i < L; i++) begin
      e = ex(S_FETCH); e.mr = 1'b1; e.asb = 2'b01;
      e.pcw = (i == L - 1); e.irw = (i == L - 1);
      step(g, e);
    end
    e = ex(S_DECODE); e.asb = 2'b11;
    e.ill = !(o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h0F});
    step(g, e);
    case (o)
      6'h00: begin
        if (f == 6'h0D) begin
          e = ex(S_HALT); e.hlt = 1'b1;
          repeat (20) step(g, e);
          rst[g] = 1'b1;
          step(g, e);
          rst[g] = 1'b0;
          step(g, ex(S_RST));
        end else begin
          e = ex(S_R_EXEC); e.asa = 1'b1; e.aop = 2'b10; step(g, e);
          e = ex(S_R_WB); e.rdst = 1'b1; e.rw = 1'b1; step(g, e);
        end
      end
      6'h23: begin
        e = ex(S_MEM_ADDR); e.asa = 1'b1; e.asb = 2'b10; step(g, e);
        e = ex(S_MEM_READ); e.iord = 1'b1; e.mr = 1'b1;
        repeat (L) step(g, e);
        e = ex(S_LOAD_WB); e.m2r = 2'b01; e.rw = 1'b1; step(g, e);
      end
      6'h2B: begin
        e = ex(S_MEM_ADDR); e.asa = 1'b1; e.asb = 2'b10; step(g, e);
        e = ex(S_MEM_WRITE); e.iord = 1'b1; e.mw = 1'b1;
        if (abort_mw) begin
          rst[g] = 1'b1;
          step(g, e);
          rst[g] = 1'b0;
          step(g, ex(S_RST));
        end else begin
          repeat (L) step(g, e);
        end
      end
      6'h04, 6'h05: begin
        e = ex(S_BRANCH); e.asa = 1'b1; e.aop = 2'b01; e.pcs = 2'b01;
        e.pcw = (o == 6'h04) ? z : ~z;
        step(g, e);
      end
      6'h02: begin
        e = ex(S_JUMP); e.pcs = 2'b10; e.pcw = 1'b1; step(g, e);
      end
      6'h0F: begin
        e = ex(S_LUI); e.m2r = 2'b10; e.rw = 1'b1; step(g, e);
      end
      default: ;
    endcase
  endtask

  task automatic run(input int g);
    rst[g] = 1'b1; op[g] = 6'h00; fn[g] = 6'h20; zr[g] = 1'b0;
    @(posedge clk);
    #1;
    rst[g] = 1'b0;
    step(g, ex(S_RST));
    instr(g, 6'h00, 6'h20, 1'b0, 1'b0);
    instr(g, 6'h23, 6'h00, 1'b0, 1'b0);
    instr(g, 6'h04, 6'h00, 1'b1, 1'b0);
    instr(g, 6'h04, 6'h00, 1'b0, 1'b0);
    instr(g, 6'h05, 6'h00, 1'b0, 1'b0);
    instr(g, 6'h05, 6'h00, 1'b1, 1'b0);
    instr(g, 6'h2B, 6'h00, 1'b0, 1'b0);
    instr(g, 6'h02, 6'h00, 1'b0, 1'b0);
    instr(g, 6'h0F, 6'h00, 1'b0, 1'b0);
    instr(g, 6'h3F, 6'h00, 1'b0, 1'b0);
    instr(g, 6'h2B, 6'h00, 1'b0, 1'b1);
    instr(g, 6'h00, 6'h0D, 1'b0, 1'b0);
    instr(g, 6'h00, 6'h22, 1'b0, 1'b0);
    instr(g, 6'h23, 6'h00, 1'b0, 1'b0);
  endtask

  initial begin
    fork
      run(0);
      run(1);
      run(2);
    join
    all_done = 1'b1;
  end

  initial begin
    int   cyc;
    ctl_t e;
    cyc = 0;
    while (!all_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      for (int g = 0; g < 3; g++) begin
        if (q[g].size() > 0) begin
          e = q[g].pop_front();
          checks++;
          if (act[g] !== e) begin
            errors++;
            $display("FAIL ctl lat%0d cycle %0d: got %h (state %0d) want %h (state %0d)",
                     g + 1, cyc, act[g], act[g].st, e, e.st);
          end
        end
      end
    end
    checks++;
    if (!all_done) begin
      errors++;
      $display("FAIL timeout: cycles %0d, program not complete", cyc);
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (q[g].size() != 0) begin
        errors++;
        $display("FAIL drain lat%0d: %0d expectations left, want 0", g + 1, q[g].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
